btb: RTL

BTB -- requirements
Module: btb

---
 rtl/btb_pkg.sv | 33 +++
 rtl/btb_sat_counter.sv | 24 ++
 rtl/btb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared BTB types and constants: entry record, counter constants, pointer width.
// Entry fields are sized for the widest supported build; the top uses the low bits.
package btb_pkg;

  localparam int ADDR_W_MAX = 32;
  localparam int CNT_W_MAX  = 8;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_MAX-1:0] tag;
    logic [ADDR_W_MAX-1:0] target;
    logic [CNT_W_MAX-1:0]  cnt;
  } btb_entry_t;

  // Weakly not-taken: value after reset and on a not-taken allocation.
  function automatic int cnt_init(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Weakly taken: value on a taken allocation.
  function automatic int cnt_alloc_taken(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int ptr_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating up/down counter next-state logic, one per BTB entry.
// Ports: cnt_i current value, up_i direction (1=inc), cnt_o next value.
module btb_sat_counter
  import btb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != MAX) cnt_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

// File: rtl/btb.sv
// Branch target buffer: fully associative, round-robin fill, combinational lookup.
// Ports: clk/rst (sync, active-high), flush, query_* -> pred_*, upd_* resolved branch.
// Define BTB_BYPASS_EN to forward a same-address update into the same-cycle query.
module btb
  import btb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken
);

  localparam int PW = ptr_w(ENTRIES);
  localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] TINIT = CNT_W'(cnt_alloc_taken(CNT_W));

  btb_entry_t tbl_q [ENTRIES];
  logic [PW-1:0] ptr_q;

  logic [CNT_W-1:0] cnt_cur [ENTRIES];
  logic [CNT_W-1:0] cnt_nxt [ENTRIES];

  logic [ADDR_W_MAX-1:0] qa_x, ua_x, ut_x;
  assign qa_x = ADDR_W_MAX'(query_addr);
  assign ua_x = ADDR_W_MAX'(upd_addr);
  assign ut_x = ADDR_W_MAX'(upd_target);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    assign cnt_cur[g] = CNT_W'(tbl_q[g].cnt);
    btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .cnt_i(cnt_cur[g]),
      .up_i (upd_taken),
      .cnt_o(cnt_nxt[g])
    );
  end

  logic          q_hit, u_hit;
  logic [PW-1:0] q_idx, u_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    q_hit = 1'b0;
    q_idx = '0;
    u_hit = 1'b0;
    u_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && tbl_q[i].tag == qa_x) begin
        q_hit = 1'b1;
        q_idx = PW'(i);
      end
      if (tbl_q[i].valid && tbl_q[i].tag == ua_x) begin
        u_hit = 1'b1;
        u_idx = PW'(i);
      end
    end
  end

  logic [CNT_W-1:0] alloc_cnt;
  assign alloc_cnt = upd_taken ? TINIT : INIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].cnt   <= CNT_W_MAX'(INIT);
      end
      ptr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      ptr_q <= '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        tbl_q[u_idx].cnt <= CNT_W_MAX'(cnt_nxt[u_idx]);
        if (upd_taken) tbl_q[u_idx].target <= ut_x;
      end else begin
        tbl_q[ptr_q].valid  <= 1'b1;
        tbl_q[ptr_q].tag    <= ua_x;
        tbl_q[ptr_q].target <= ut_x;
        tbl_q[ptr_q].cnt    <= CNT_W_MAX'(alloc_cnt);
        ptr_q <= ptr_q + PW'(1);
      end
    end
  end

  logic              hit_w;
  logic [CNT_W-1:0]  cnt_w;
  logic [ADDR_W-1:0] tgt_w;

`ifdef BTB_BYPASS_EN
  logic              fwd;
  logic [CNT_W-1:0]  fwd_cnt;
  logic [ADDR_W-1:0] fwd_tgt;

  // rst gating happens on the outputs below, so only flush blocks here.
  assign fwd = upd_valid && !flush && (upd_addr == query_addr);
  assign fwd_cnt = u_hit ? cnt_nxt[u_idx] : alloc_cnt;
  assign fwd_tgt = (u_hit && !upd_taken) ?
                   ADDR_W'(tbl_q[u_idx].target) : upd_target;

  assign hit_w = fwd | q_hit;
  assign cnt_w = fwd ? fwd_cnt : cnt_cur[q_idx];
  assign tgt_w = fwd ? fwd_tgt : ADDR_W'(tbl_q[q_idx].target);
`else
  assign hit_w = q_hit;
  assign cnt_w = cnt_cur[q_idx];
  assign tgt_w = ADDR_W'(tbl_q[q_idx].target);
`endif

  assign pred_hit    = !rst && hit_w;
  assign pred_taken  = pred_hit && cnt_w[CNT_W-1];
  assign pred_target = pred_taken ? tgt_w : '0;

endmodule
